// File: rtl/regfile_wb_ctrl.sv
// Register-file writeback controller: ALU result FIFO merged with load responses, load formatting,
// pending-load mask and operand forwarding (forwarding enabled by defining WB_FWD_EN).
module regfile_wb_ctrl #(
  parameter int FIFO_DEPTH = 2,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            ld_valid,
  input  logic [4:0]      ld_rd,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_addr_lo,
  output logic            ld_ready,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            w_enb,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] w_data,
  output logic [31:0]     pend_mask,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [XLEN-1:0] r_data1_in,
  input  logic [XLEN-1:0] r_data2_in,
  output logic [XLEN-1:0] fwd_data1,
  output logic [XLEN-1:0] fwd_data2,
  output logic            dbg_state
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int OW = $clog2(XLEN);

  typedef enum logic {IDLE = 1'b0, LD_WAIT = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [4:0]        cap_rd_q, cap_rd_d;
  logic [2:0]        cap_f3_q, cap_f3_d;
  logic [1:0]        cap_lo_q, cap_lo_d;
  logic [31:0]       pend_q, pend_d;
  logic [4:0]        fifo_rd_q   [FIFO_DEPTH];
  logic [4:0]        fifo_rd_d   [FIFO_DEPTH];
  logic [XLEN-1:0]   fifo_data_q [FIFO_DEPTH];
  logic [XLEN-1:0]   fifo_data_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_vld_q, fifo_vld_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              w_enb_q, w_enb_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   w_data_q, w_data_d;

  logic              fifo_full, fifo_empty, ld_conflict;
  logic              alu_push, ld_push, ld_done, fifo_pop;
  logic [OW-1:0]     byte_off, half_off;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [XLEN-1:0]   ld_fmt;

  // Handshake: a transfer happens on a cycle where valid && ready; ready never
  // depends on valid of the same channel, and mem_rvalid has no backpressure.
  always_comb begin
    fifo_full   = (count_q == CW'(FIFO_DEPTH));
    fifo_empty  = (count_q == '0);
    ld_conflict = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (fifo_vld_q[i] && (fifo_rd_q[i] == ld_rd)) ld_conflict = 1'b1;
    end
    ld_ready  = (state_q == IDLE) && !ld_conflict;
    alu_ready = !fifo_full &&
                !((state_q == LD_WAIT) && (alu_rd == cap_rd_q) && (alu_rd != 5'd0));
    alu_push  = alu_valid && alu_ready;
    ld_push   = ld_valid && ld_ready;
    ld_done   = (state_q == LD_WAIT) && mem_rvalid;
    fifo_pop  = !ld_done && !fifo_empty;
  end

  always_comb begin
    byte_off = OW'({cap_lo_q, 3'b000});
    half_off = OW'({cap_lo_q[1], 4'b0000});
    ld_byte  = mem_rdata[byte_off +: 8];
    ld_half  = mem_rdata[half_off +: 16];
    case (cap_f3_q)
      3'b000:  ld_fmt = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_fmt = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  ld_fmt = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_fmt = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_fmt = mem_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cap_rd_d = cap_rd_q;
    cap_f3_d = cap_f3_q;
    cap_lo_d = cap_lo_q;
    pend_d   = pend_q;
    case (state_q)
      IDLE: begin
        if (ld_push) begin
          state_d  = LD_WAIT;
          cap_rd_d = ld_rd;
          cap_f3_d = ld_funct3;
          cap_lo_d = ld_addr_lo;
          if (ld_rd != 5'd0) pend_d[ld_rd] = 1'b1;
        end
      end
      LD_WAIT: begin
        if (mem_rvalid) begin
          state_d          = IDLE;
          pend_d[cap_rd_q] = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    pend_d[0] = 1'b0;
  end

  // Load response wins the write port; the FIFO head waits a cycle.
  always_comb begin
    w_enb_d     = 1'b0;
    rd_d        = rd_q;
    w_data_d    = w_data_q;
    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;
    fifo_vld_d  = fifo_vld_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (ld_done) begin
      w_enb_d  = (cap_rd_q != 5'd0);
      rd_d     = cap_rd_q;
      w_data_d = ld_fmt;
    end else if (fifo_pop) begin
      w_enb_d              = (fifo_rd_q[rd_ptr_q] != 5'd0);
      rd_d                 = fifo_rd_q[rd_ptr_q];
      w_data_d             = fifo_data_q[rd_ptr_q];
      fifo_vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d             = rd_ptr_q + PW'(1);
    end
    if (alu_push) begin
      fifo_rd_d[wr_ptr_q]   = alu_rd;
      fifo_data_d[wr_ptr_q] = alu_data;
      fifo_vld_d[wr_ptr_q]  = 1'b1;
      wr_ptr_d              = wr_ptr_q + PW'(1);
    end
    case ({alu_push, fifo_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cap_rd_q   <= '0;
      cap_f3_q   <= '0;
      cap_lo_q   <= '0;
      pend_q     <= '0;
      fifo_vld_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      w_enb_q    <= 1'b0;
      rd_q       <= '0;
      w_data_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_rd_q[i]   <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cap_rd_q    <= cap_rd_d;
      cap_f3_q    <= cap_f3_d;
      cap_lo_q    <= cap_lo_d;
      pend_q      <= pend_d;
      fifo_vld_q  <= fifo_vld_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      w_enb_q     <= w_enb_d;
      rd_q        <= rd_d;
      w_data_q    <= w_data_d;
      fifo_rd_q   <= fifo_rd_d;
      fifo_data_q <= fifo_data_d;
    end
  end

  assign w_enb     = w_enb_q;
  assign rd        = rd_q;
  assign w_data    = w_data_q;
  assign pend_mask = pend_q;
  assign dbg_state = (state_q == LD_WAIT);

`ifdef WB_FWD_EN
  // Bypass the write landing at the coming edge so decode sees it this cycle.
  always_comb begin
    fwd_data1 = (w_enb_q && (rd_q != 5'd0) && (rd_q == rs1)) ? w_data_q : r_data1_in;
    fwd_data2 = (w_enb_q && (rd_q != 5'd0) && (rd_q == rs2)) ? w_data_q : r_data2_in;
  end
`else
  logic unused_rs;
  assign unused_rs = ^{rs1, rs2};
  assign fwd_data1 = r_data1_in;
  assign fwd_data2 = r_data2_in;
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: directed vectors, a load-format table and a queue-based reference model under random traffic.
module tb_regfile_wb_ctrl;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
`ifdef WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            alu_valid, alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_valid, ld_ready;
  logic [4:0]      ld_rd;
  logic [2:0]      ld_funct3;
  logic [1:0]      ld_addr_lo;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            w_enb;
  logic [4:0]      rd;
  logic [XLEN-1:0] w_data;
  logic [31:0]     pend_mask;
  logic [4:0]      rs1, rs2;
  logic [XLEN-1:0] r_data1_in, r_data2_in, fwd_data1, fwd_data2;
  logic            dbg_state;

  regfile_wb_ctrl #(.FIFO_DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo),
    .ld_ready(ld_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .w_enb(w_enb), .rd(rd), .w_data(w_data), .pend_mask(pend_mask),
    .rs1(rs1), .rs2(rs2), .r_data1_in(r_data1_in), .r_data2_in(r_data2_in),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .dbg_state(dbg_state)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } alu_ent_t;

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] rdata;
    logic [31:0] exp;
  } fmt_vec_t;

  // Reference model: ALU queue, one outstanding load, registered write port.
  alu_ent_t    m_alu_q[$];
  bit          m_ld_pend;
  logic [4:0]  m_ld_rd;
  logic [2:0]  m_ld_f3;
  logic [1:0]  m_ld_lo;
  logic        m_wenb;
  logic [4:0]  m_rd;
  logic [31:0] m_wdata;
  logic [36:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] w);
    int unsigned b, h, sh_b, sh_h;
    sh_b = 8 * int'(lo);
    sh_h = 16 * (int'(lo) / 2);
    b = (w >> sh_b) & 32'hFF;
    h = (w >> sh_h) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? (b - 256) : b;
      3'd1:    return (h >= 32768) ? (h - 65536) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic bit m_ld_ready(input logic [4:0] r);
    if (m_ld_pend) return 1'b0;
    foreach (m_alu_q[i]) if (m_alu_q[i].rd == r) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_alu_ready(input logic [4:0] r);
    return (m_alu_q.size() < DEPTH) && !(m_ld_pend && r == m_ld_rd && r != 5'd0);
  endfunction

  task automatic model_reset();
    m_alu_q.delete();
    exp_q.delete();
    m_ld_pend = 1'b0;
    m_ld_rd   = '0;
    m_ld_f3   = '0;
    m_ld_lo   = '0;
    m_wenb    = 1'b0;
    m_rd      = '0;
    m_wdata   = '0;
  endtask

  task automatic set_idle();
    alu_valid  = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid   = 1'b0; ld_rd = '0; ld_funct3 = 3'd2; ld_addr_lo = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    rs1 = '0; rs2 = '0; r_data1_in = '0; r_data2_in = '0;
  endtask

  // Caller sits at posedge+1 with inputs driven; settle moves to the negedge.
  task automatic settle();
    #4;
  endtask

  task automatic finish_cycle();
    bit acc_a, acc_l;
    alu_ent_t e;
    logic [31:0] f1, f2;
    logic [36:0] exp_w;
    if (rst) begin
      chk("alu_ready", alu_ready, m_alu_ready(alu_rd));
      chk("ld_ready", ld_ready, m_ld_ready(ld_rd));
    end
    f1 = (FWD && m_wenb && m_rd != 5'd0 && m_rd == rs1) ? m_wdata : r_data1_in;
    f2 = (FWD && m_wenb && m_rd != 5'd0 && m_rd == rs2) ? m_wdata : r_data2_in;
    chk("fwd_data1", fwd_data1, f1);
    chk("fwd_data2", fwd_data2, f2);
    if (!rst) begin
      model_reset();
    end else begin
      acc_a  = alu_valid && m_alu_ready(alu_rd);
      acc_l  = ld_valid && m_ld_ready(ld_rd);
      m_wenb = 1'b0;
      if (m_ld_pend && mem_rvalid) begin
        m_rd      = m_ld_rd;
        m_wdata   = fmt_load(m_ld_f3, m_ld_lo, mem_rdata);
        m_wenb    = (m_ld_rd != 5'd0);
        m_ld_pend = 1'b0;
      end else if (m_alu_q.size() > 0) begin
        e       = m_alu_q.pop_front();
        m_rd    = e.rd;
        m_wdata = e.data;
        m_wenb  = (e.rd != 5'd0);
      end
      if (m_wenb) exp_q.push_back({m_rd, m_wdata});
      if (acc_a) m_alu_q.push_back('{rd: alu_rd, data: alu_data});
      if (acc_l) begin
        m_ld_pend = 1'b1;
        m_ld_rd   = ld_rd;
        m_ld_f3   = ld_funct3;
        m_ld_lo   = ld_addr_lo;
      end
    end
    @(posedge clk);
    #1;
    chk("w_enb", w_enb, m_wenb);
    chk("pend_mask", pend_mask, (m_ld_pend && m_ld_rd != 5'd0) ? (32'h1 << m_ld_rd) : 32'h0);
    if (w_enb === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL write_order: got rd=%0d data=%0h expected no write", rd, w_data);
      end else begin
        exp_w = exp_q.pop_front();
        chk("write_rd_data", {rd, w_data}, exp_w);
      end
    end
  endtask

  task automatic run_cycle();
    settle();
    finish_cycle();
  endtask

  task automatic idle_cycles(input int n);
    set_idle();
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  fmt_vec_t vecs[12];

  initial begin
    vecs[0]  = '{f3: 3'b000, lo: 2'd3, rdata: 32'h80FF_1234, exp: 32'hFFFF_FF80};
    vecs[1]  = '{f3: 3'b100, lo: 2'd3, rdata: 32'h80FF_1234, exp: 32'h0000_0080};
    vecs[2]  = '{f3: 3'b001, lo: 2'd2, rdata: 32'h80FF_1234, exp: 32'hFFFF_80FF};
    vecs[3]  = '{f3: 3'b010, lo: 2'd3, rdata: 32'h80FF_1234, exp: 32'h80FF_1234};
    vecs[4]  = '{f3: 3'b101, lo: 2'd2, rdata: 32'h80FF_1234, exp: 32'h0000_80FF};
    vecs[5]  = '{f3: 3'b000, lo: 2'd0, rdata: 32'h80FF_1234, exp: 32'h0000_0034};
    vecs[6]  = '{f3: 3'b001, lo: 2'd0, rdata: 32'h80FF_1234, exp: 32'h0000_1234};
    vecs[7]  = '{f3: 3'b000, lo: 2'd1, rdata: 32'h80FF_1234, exp: 32'h0000_0012};
    vecs[8]  = '{f3: 3'b011, lo: 2'd1, rdata: 32'h80FF_1234, exp: 32'h80FF_1234};
    vecs[9]  = '{f3: 3'b110, lo: 2'd2, rdata: 32'h0102_8384, exp: 32'h0102_8384};
    vecs[10] = '{f3: 3'b100, lo: 2'd2, rdata: 32'h80FF_1234, exp: 32'h0000_00FF};
    vecs[11] = '{f3: 3'b001, lo: 2'd1, rdata: 32'h1234_8001, exp: 32'hFFFF_8001};

    set_idle();
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset held with ALU traffic offered
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h11;
    for (int i = 0; i < 2; i++) begin
      run_cycle();
      chk("rst_w_enb", w_enb, 1'b0);
      chk("rst_pend", pend_mask, 32'h0);
      chk("rst_rd", rd, 5'd0);
      chk("rst_w_data", w_data, 32'h0);
      chk("rst_state", dbg_state, 1'b0);
    end

    // Release; ALU stream 5/6/7 back to back
    rst = 1'b1;
    run_cycle();
    chk("stream_lat0", w_enb, 1'b0);
    alu_rd = 5'd6; alu_data = 32'h22;
    run_cycle();
    chk("stream_w0", {w_enb, rd, w_data}, {1'b1, 5'd5, 32'h11});
    alu_rd = 5'd7; alu_data = 32'h33;
    run_cycle();
    chk("stream_w1", {w_enb, rd, w_data}, {1'b1, 5'd6, 32'h22});
    alu_valid = 1'b0;
    run_cycle();
    chk("stream_w2", {w_enb, rd, w_data}, {1'b1, 5'd7, 32'h33});
    run_cycle();
    chk("stream_done", w_enb, 1'b0);

    // Load to x9, WAW stall of alu_rd=9, collision with FIFO head x3, FIFO full
    set_idle();
    ld_valid = 1'b1; ld_rd = 5'd9; ld_funct3 = 3'b010;
    run_cycle();
    chk("ld9_pend", pend_mask, 32'h0000_0200);
    chk("ld9_state", dbg_state, 1'b1);
    ld_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    settle();
    chk("waw_alu_ready", alu_ready, 1'b0);
    finish_cycle();
    alu_rd = 5'd3; alu_data = 32'h333;
    settle();
    chk("alu3_ready", alu_ready, 1'b1);
    finish_cycle();
    alu_rd = 5'd4; alu_data = 32'h444;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001;
    run_cycle();
    chk("coll_load_first", {w_enb, rd, w_data}, {1'b1, 5'd9, 32'hCAFE_0001});
    chk("coll_pend_clr", pend_mask, 32'h0);
    mem_rvalid = 1'b0;
    alu_rd = 5'd9; alu_data = 32'h999;
    settle();
    chk("full_alu_ready", alu_ready, 1'b0);
    finish_cycle();
    chk("coll_alu_next", {w_enb, rd, w_data}, {1'b1, 5'd3, 32'h333});
    settle();
    chk("x9_after_load", alu_ready, 1'b1);
    finish_cycle();
    chk("coll_alu4", {w_enb, rd, w_data}, {1'b1, 5'd4, 32'h444});
    alu_valid = 1'b0;
    run_cycle();
    chk("coll_alu9", {w_enb, rd, w_data}, {1'b1, 5'd9, 32'h999});
    idle_cycles(2);

    // ld_ready held low while an x4 entry is queued
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h4444;
    run_cycle();
    alu_valid = 1'b0;
    ld_valid = 1'b1; ld_rd = 5'd4; ld_funct3 = 3'b010;
    settle();
    chk("waw_ld_ready", ld_ready, 1'b0);
    finish_cycle();
    settle();
    chk("ld_ready_drained", ld_ready, 1'b1);
    finish_cycle();
    ld_valid = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    run_cycle();
    chk("ld4_write", {w_enb, rd, w_data}, {1'b1, 5'd4, 32'h5555_AAAA});
    idle_cycles(1);

    // Load to x0: consumed, never written, never pending
    ld_valid = 1'b1; ld_rd = 5'd0;
    run_cycle();
    chk("ld0_pend", pend_mask, 32'h0);
    ld_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    run_cycle();
    chk("ld0_no_write", w_enb, 1'b0);
    idle_cycles(1);

    // Load formatting table
    for (int i = 0; i < 12; i++) begin
      set_idle();
      ld_valid = 1'b1; ld_rd = 5'(i + 1);
      ld_funct3 = vecs[i].f3; ld_addr_lo = vecs[i].lo;
      run_cycle();
      ld_valid = 1'b0;
      if (i % 3 == 0) run_cycle();
      mem_rvalid = 1'b1; mem_rdata = vecs[i].rdata;
      run_cycle();
      chk($sformatf("fmt_vec%0d", i), {w_enb, rd, w_data}, {1'b1, 5'(i + 1), vecs[i].exp});
    end
    idle_cycles(1);

    // Reset during LD_WAIT discards the load
    ld_valid = 1'b1; ld_rd = 5'd12;
    run_cycle();
    chk("mid_pend", pend_mask, 32'h0000_1000);
    ld_valid = 1'b0; rst = 1'b0;
    run_cycle();
    chk("mid_rst_pend", pend_mask, 32'h0);
    rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    run_cycle();
    chk("mid_no_write", w_enb, 1'b0);
    chk("mid_state", dbg_state, 1'b0);
    idle_cycles(1);

    // Forwarding of the write landing this edge
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hABCD;
    run_cycle();
    alu_valid = 1'b0;
    run_cycle();
    rs1 = 5'd7; rs2 = 5'd8; r_data1_in = 32'h1111; r_data2_in = 32'h2222;
    settle();
    chk("fwd1_hit", fwd_data1, FWD ? 32'hABCD : 32'h1111);
    chk("fwd2_miss", fwd_data2, 32'h2222);
    finish_cycle();
    idle_cycles(1);

    // Random traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 199) != 0);
      alu_valid  = ($urandom_range(0, 1) == 1);
      alu_rd     = 5'($urandom_range(0, 7));
      alu_data   = $urandom;
      ld_valid   = ($urandom_range(0, 2) == 0);
      ld_rd      = 5'($urandom_range(0, 7));
      ld_funct3  = 3'($urandom_range(0, 7));
      ld_addr_lo = 2'($urandom_range(0, 3));
      mem_rvalid = ($urandom_range(0, 2) == 0);
      mem_rdata  = $urandom;
      rs1        = 5'($urandom_range(0, 7));
      rs2        = 5'($urandom_range(0, 7));
      r_data1_in = $urandom;
      r_data2_in = $urandom;
      run_cycle();
    end

    // Drain
    set_idle();
    rst = 1'b1;
    mem_rvalid = 1'b1;
    run_cycle();
    idle_cycles(4);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
